// File: rtl/spi_flash_rd_arb.sv
// Two-port round-robin read controller for a SPI mode-0 NOR flash (0x03 READ, 24-bit address).
// Each accepted request issues one 64-bit frame and returns a 32-bit little-endian word.
module spi_flash_rd_arb #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StGap} state_e;

  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  localparam logic [15:0] GapLast = 16'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [15:0] gap_q, gap_d;
  logic [63:0] sr_q, sr_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        gnt_q, gnt_d;  // port owning the transaction in flight
  logic        ptr_q, ptr_d;  // port favoured when both request
  logic        win;
  logic        accept;
  logic [63:0] frame;
  logic [31:0] rx_word;

  always_comb begin
    win        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    accept     = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !win;
    req1_ready = accept && win;
    frame      = {8'h03, (win ? req1_addr : req0_addr), 32'h0};
    // Flash streams B0 first, MSB first; B0 becomes the least significant byte.
    rx_word    = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          gnt_d   = win;
          ptr_d   = ~win;
          sr_d    = frame;
          mosi_d  = frame[63];
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[30:0], spi_miso};
          end else if (bit_q == 6'd63) begin
            state_d = StDone;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            if (gnt_q) rdata1_d = rx_word;
            else       rdata0_d = rx_word;
          end else begin
            bit_d  = bit_q + 6'd1;
            sr_d   = {sr_q[62:0], 1'b0};
            mosi_d = sr_q[62];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StGap;
        gap_d   = '0;
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      gnt_q    <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign req0_rvalid = (state_q == StDone) && !gnt_q;
  assign req1_rvalid = (state_q == StDone) && gnt_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_flash_rd_arb.sv
// Randomised bench for spi_flash_rd_arb: two instances (CLK_DIV 2 and 1), each with a flash
// model and a transaction-level reference checking arbitration, SPI waveform and read data.
module tb_spi_flash_rd_arb;

  logic        clk;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          done [2] = '{0, 0};

  logic        rst    [2];
  logic        valid  [2][2];
  logic [23:0] addr   [2][2];
  logic        ready  [2][2];
  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];
  logic        cs_n   [2];
  logic        sck    [2];
  logic        mosi   [2];
  logic        miso   [2];
  logic [31:0] fcmd   [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  task automatic do_reset(input int g);
    rst[g] = 1'b1;
    valid[g][0] = 1'b0;
    valid[g][1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst[g] = 1'b0;
  endtask

  // Starts just after a posedge; holds valid for up to 'hold' cycles or until accepted.
  task automatic issue(input int g, input int p, input logic [23:0] a, input int hold,
                       output bit acc);
    acc = 1'b0;
    valid[g][p] = 1'b1;
    addr[g][p] = a;
    for (int k = 0; k < hold && !acc; k++) begin
      @(negedge clk);
      acc = ready[g][p];
      @(posedge clk);
      #1;
    end
    valid[g][p] = 1'b0;
    addr[g][p] = 24'($urandom);
    if (hold >= 1000) chk("accept_seen", acc, 1);
  endtask

  task automatic wait_rv(input int g, input int p);
    bit seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = rvalid[g][p];
    end
    chk("rvalid_seen", seen, 1);
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 2 : 1;
    localparam int unsigned G = 4;

    spi_flash_rd_arb #(
      .CLK_DIV(D),
      .GAP_CYC(G)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req0_valid (valid[g][0]),
      .req0_addr  (addr[g][0]),
      .req0_ready (ready[g][0]),
      .req0_rvalid(rvalid[g][0]),
      .req0_rdata (rdata[g][0]),
      .req1_valid (valid[g][1]),
      .req1_addr  (addr[g][1]),
      .req1_ready (ready[g][1]),
      .req1_rvalid(rvalid[g][1]),
      .req1_rdata (rdata[g][1]),
      .spi_cs_n   (cs_n[g]),
      .spi_sck    (sck[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso[g])
    );

    // Flash model: captures command/address on SCK rise, shifts data out on SCK fall and
    // deliberately corrupts MISO while SCK is high.
    int          fcnt = 0;
    logic [31:0] fstream;
    always @(negedge cs_n[g]) fcnt = 0;
    always @(posedge sck[g]) begin
      if (!cs_n[g]) begin
        if (fcnt < 32) fcmd[g] = {fcmd[g][30:0], mosi[g]};
        fcnt++;
        if (fcnt == 32)
          fstream = {fbyte(fcmd[g][23:0]), fbyte(fcmd[g][23:0] + 24'd1),
                     fbyte(fcmd[g][23:0] + 24'd2), fbyte(fcmd[g][23:0] + 24'd3)};
        miso[g] = ~miso[g];
      end
    end
    always @(negedge sck[g]) begin
      if (!cs_n[g] && fcnt >= 32 && fcnt < 64) miso[g] = fstream[63 - fcnt];
    end

    // Transaction-level reference.
    bit          pend, ptr, shifting, idle, e0, e1, erv0, erv1, pport;
    int unsigned acc_c, due, m_next, k;
    logic [23:0] paddr;
    logic [63:0] frame;
    logic [31:0] exp_rd [2];

    always @(negedge clk) begin
      if (rst[g]) begin
        pend = 1'b0;
        ptr = 1'b0;
        m_next = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk("rst_cs_n", cs_n[g], 1);
        chk("rst_sck", sck[g], 0);
        chk("rst_mosi", mosi[g], 0);
        chk("rst_ready", {ready[g][1], ready[g][0]}, 0);
        chk("rst_rvalid", {rvalid[g][1], rvalid[g][0]}, 0);
        chk("rst_rdata0", rdata[g][0], 0);
        chk("rst_rdata1", rdata[g][1], 0);
      end else begin
        shifting = pend && cyc > acc_c && cyc < due;
        chk("cs_n", cs_n[g], !shifting);
        if (shifting) begin
          k = cyc - acc_c - 1;
          frame = {8'h03, paddr, 32'h0};
          chk("sck", sck[g], (k % (2 * D)) >= D);
          chk("mosi", mosi[g], frame[63 - k / (2 * D)]);
        end else begin
          chk("sck_idle", sck[g], 0);
        end
        erv0 = pend && cyc == due && !pport;
        erv1 = pend && cyc == due && pport;
        if (rvalid[g][0] || erv0) chk("rvalid0", rvalid[g][0], erv0);
        if (rvalid[g][1] || erv1) chk("rvalid1", rvalid[g][1], erv1);
        if (pend && cyc == due) begin
          exp_rd[pport] = flash_word(paddr);
          chk("rdata0", rdata[g][0], exp_rd[0]);
          chk("rdata1", rdata[g][1], exp_rd[1]);
          chk("flash_cmd", fcmd[g], {8'h03, paddr});
          pend = 1'b0;
        end
        idle = !pend && cyc >= m_next;
        e0 = idle && valid[g][0] && (!valid[g][1] || !ptr);
        e1 = idle && valid[g][1] && (!valid[g][0] || ptr);
        if (valid[g][0] || valid[g][1] || ready[g][0] || ready[g][1]) begin
          chk("ready0", ready[g][0], e0);
          chk("ready1", ready[g][1], e1);
        end
        if (e0 || e1) begin
          pend = 1'b1;
          pport = e1;
          paddr = e1 ? addr[g][1] : addr[g][0];
          acc_c = cyc;
          due = cyc + 1 + 128 * D;
          m_next = due + 1 + G;
          ptr = !e1;
        end
      end
    end

    initial begin : stim
      bit acc, acc0, acc1;
      int p, hold;
      miso[g] = 1'b0;
      addr[g][0] = '0;
      addr[g][1] = '0;
      do_reset(g);
      issue(g, 0, 24'h000100, 1000, acc);
      wait_rv(g, 0);
      chk("single_rd", rdata[g][0], 32'h4433_2211);
      issue(g, 0, 24'h000104, 1000, acc);
      wait_rv(g, 0);

      do_reset(g);
      fork
        issue(g, 0, 24'h000000, 1000, acc0);
        issue(g, 1, 24'h000004, 1000, acc1);
      join
      wait_rv(g, 1);
      chk("simul_rd0", rdata[g][0], flash_word(24'h000000));
      chk("simul_rd1", rdata[g][1], flash_word(24'h000004));

      fork
        begin
          for (int i = 0; i < 3; i++) issue(g, 0, 24'($urandom), 1000, acc0);
        end
        begin
          for (int i = 0; i < 3; i++) issue(g, 1, 24'($urandom), 1000, acc1);
        end
      join
      wait_rv(g, 1);

      issue(g, 1, 24'($urandom), 1000, acc);
      wait_rv(g, 1);
      fork
        issue(g, 0, 24'($urandom), 1000, acc0);
        issue(g, 1, 24'($urandom), 1000, acc1);
      join
      wait_rv(g, 1);

      issue(g, 0, 24'h000003, 1000, acc);
      wait_rv(g, 0);
      chk("unaligned_rd", rdata[g][0], {fbyte(24'd6), fbyte(24'd5), fbyte(24'd4), fbyte(24'd3)});
      issue(g, 1, 24'hFFFFFE, 1000, acc);
      wait_rv(g, 1);
      chk("top_cmd", fcmd[g], 32'h03FF_FFFE);
      chk("top_rd", rdata[g][1], {fbyte(24'h000001), fbyte(24'h000000),
                                  fbyte(24'hFFFFFF), fbyte(24'hFFFFFE)});

      for (int i = 0; i < 8; i++) begin
        p = $urandom_range(0, 1);
        hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 1000;
        issue(g, p, 24'($urandom), hold, acc);
        if (acc) wait_rv(g, p);
      end

      issue(g, 0, 24'($urandom), 1000, acc);
      repeat (41 * D) @(posedge clk);
      #2 rst[g] = 1'b1;
      #1;
      chk("async_rst_cs_n", cs_n[g], 1);
      chk("async_rst_sck", sck[g], 0);
      repeat (2) @(posedge clk);
      #1 rst[g] = 1'b0;
      issue(g, 1, 24'h000102, 1000, acc);
      wait_rv(g, 1);
      chk("post_rst_rd", rdata[g][1], flash_word(24'h000102));
      chk("post_rst_rd0_clear", rdata[g][0], 0);
      done[g] = 1'b1;
    end
  end

  initial begin
    fork
      wait (done[0] && done[1]);
      #2_000_000;
    join_any
    chk("all_done", {31'b0, done[0] & done[1]}, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_flash_rd_arb.md
Name: spi_flash_rd_arb

Overview:
- Two-port arbitrated read controller for the board's serial NOR flash (SPI mode 0, command 0x03 READ, 24-bit address).
- Sits between the SoC-side requesters and the flash pins:
  - port 0 is instruction fetch / XIP;
  - port 1 is debug/DMA access.
- Grants one requester at a time (round-robin), serialises the command and address, and returns one 32-bit little-endian word per request.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles; legal values 1..255.
- GAP_CYC, 4, minimum clk cycles spi_cs_n is held high between transactions; must be >=1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req0_valid  input  1  port 0 read request
- req0_addr  input  24  port 0 byte address
- req0_ready  output  1  port 0 request accepted this cycle
- req0_rvalid  output  1  port 0 read data valid, 1-cycle pulse
- req0_rdata  output  32  port 0 read data
- req1_valid / req1_addr / req1_ready / req1_rvalid / req1_rdata: same as port 0, for port 1
- spi_cs_n  output  1  flash chip select, active-low
- spi_sck  output  1  flash serial clock
- spi_mosi  output  1  controller-to-flash data
- spi_miso  input  1  flash-to-controller data

Behaviour:
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, all ready/rvalid=0, rdata=0, FSM=IDLE, RR pointer favours port 0.
- States:
  - IDLE: CS high.
  - SHIFT: CS low, 64 bits.
  - DONE: 1 cycle.
  - GAP: CS high for GAP_CYC cycles, then back to IDLE.
- Arbitration (IDLE only):
  - Exactly one valid: that port wins.
  - Both valid: port not granted last time wins.
  - After a grant, the pointer flips to the other port.
- Handshake:
  - In IDLE, reqN_ready=1 combinationally only for the winning port with valid=1; the transfer occurs on valid&ready.
  - ready is 0 in all other states; a losing or busy port must hold valid and addr.
  - addr is captured at acceptance; later changes are ignored.
  - No outstanding-request queue: at most one transaction in flight.
- Frame: 64-bit shift register {8'h03, addr[23:0], 32'h0}, MSB first. Accept at cycle T; SHIFT entered at T+1.
  - T+1: spi_cs_n=0 and spi_mosi=bit 63.
  - Each bit: spi_sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_miso is sampled on the clk edge that drives spi_sck 0->1.
  - spi_mosi updates only on the edge that drives spi_sck 1->0.
  - SPI mode 0; spi_sck always idles low.
- Data assembly:
  - The last 32 sampled bits form 4 bytes in flash order B0..B3 (B0 from addr).
  - rdata = {B3,B2,B1,B0}.
  - Unaligned addresses are legal; no wrap inside the flash beyond 24-bit rollover (0xFFFFFF then 0x000000, handled by the flash).
- Completion:
  - After bit 0's high phase, spi_sck returns low and spi_cs_n=1 at cycle T+1+128*CLK_DIV.
  - At that same cycle (DONE), reqN_rvalid=1 for exactly one cycle to the granted port, with reqN_rdata valid.
  - rdata holds its value until that port's next rvalid; the other port's rdata is untouched.
- Throughput: next acceptance no earlier than T+2+128*CLK_DIV+GAP_CYC.
- Request withdrawn: if a valid drops before acceptance, no transaction is started.
- Reset mid-transaction:
  - Immediately (asynchronously) spi_cs_n=1, spi_sck=0.
  - No rvalid is emitted; the in-flight request is dropped and the requester must reissue.
- Hazards: no combinational path from spi_miso to any output; rvalid never coincides with ready for the same port.

Test Plan:
- Single read, CLK_DIV=2, GAP_CYC=4: flash[0x000100..103]=11,22,33,44; port 0 reads 0x000100 accepted at T -> CS low T+1..T+256, MOSI stream 0x03,0x00,0x01,0x00, req0_rvalid at T+257 with rdata 0x44332211, ready again at T+262.
- Simultaneous requests on a fresh reset: port 0 addr 0x000000, port 1 addr 0x000004 -> port 0 served first, then port 1; each rvalid only on its own port, with correct data.
- Fairness: both ports valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; pointer verified after a solo port 1 request (next tie goes to port 0).
- Unaligned and top-of-flash: read 0x000003 returns {B6,B5,B4,B3}; read 0xFFFFFE issues address bytes FF,FF,FE.
- CLK_DIV=1: SCK period 2 clk cycles, rvalid at T+129; check MISO sampling on the rising edge only, against the flash model.
- Reset asserted mid-SHIFT (bit 20) -> CS high and SCK low in the same cycle, no rvalid; after release a new request completes normally with correct data.
